lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR. It generalises the single-bit reset-to-zero dff into a WIDTH-bit register with configurable feedback taps, a non-zero reset seed, a runtime seed load and a step enable.
- Tracks steps since the last reset or load, and reports completion of a full period and its length.
- Sits beside the pseudo-random and test-pattern logic as the reusable sequence source.

Parameters:
- WIDTH, 4, state width in bits; must be ≥ 2.
- TAPS, 4'b0011, feedback mask of WIDTH bits. Bit i set means q[i] is XORed into the feedback.
- RESET_SEED, 4'b1000, state loaded on reset. Must be non-zero and WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance the LFSR one step this cycle
- load  input  1  load seed this cycle
- seed  input  WIDTH  value to load
- q  output  WIDTH  present LFSR state (registered)
- out_bit  output  1  serial output; equals q[0] combinationally from the register
- count  output  WIDTH  steps taken since the last reset, load or period completion
- period_len  output  WIDTH  length of the last completed period
- period_done  output  1  one-cycle pulse when a step returns q to the start value
- zero_seed  output  1  one-cycle pulse when an all-zero seed was rejected

Behaviour:
- All state updates on the rising edge of clk. Priority is rst > load > en.
- Reset (rst=1 at the edge):
  - q=RESET_SEED, start=RESET_SEED, count=0, period_len=0, period_done=0, zero_seed=0.
  - Applies mid-operation regardless of en or load.
- Step (en=1, load=0):
  - fb = XOR-reduce(q & TAPS).
  - q_next = {fb, q[WIDTH-1:1]}, i.e. shift toward bit 0 with fb entering at the MSB.
- Period tracking on a step:
  - If q_next == start: count <= 0, period_len <= count+1, period_done <= 1.
  - Otherwise: count <= count+1 (modulo 2^WIDTH), period_done <= 0.
- Hold (en=0, load=0): q, count, period_len and start are unchanged; period_done=0, zero_seed=0.
- Load (load=1, en ignored):
  - seed ≠ 0: q=seed, start=seed, zero_seed=0.
  - seed == 0: q=RESET_SEED, start=RESET_SEED, zero_seed=1 for exactly one cycle. The all-zero lock-up state is never entered.
  - In both cases count=0 and period_done=0. period_len keeps its previous value.
- Internal register start holds the reference value for period detection. It is updated only on reset or load.
- Pulses: period_done and zero_seed are high for exactly the cycle after the triggering edge and clear on the next edge unless re-triggered.
- Non-invertible taps (TAPS[0]=0): the sequence may never return to start. count then wraps modulo 2^WIDTH silently, and period_done never asserts. This is not an error.
- Latency:
  - q reflects a step or load one clock after the triggering edge.
  - out_bit tracks q with no additional latency.
- No combinational path from any input to any output.

Test Plan:
- Reset, full sequence: defaults, rst 2 cycles, then en=1 for 15 cycles.
  - Required q sequence: 1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011,0001,1000.
  - out_bit matches q[0] each cycle.
  - period_done high only in the cycle q returns to 1000, with period_len=15 and count=0 there.
- Hold: after 3 steps (q=1001, count=3), drive en=0 for 5 cycles → q stays 1001, count stays 3, no pulses; on resuming, next q=1100.
- Load: mid-run load=1, seed=4'b0110, en=1 in the same cycle.
  - q=0110, count=0, en is ignored.
  - Continuing steps give 1011,0101,…; period_done fires when q next equals 0110, after 15 steps, with period_len=15.
- Zero seed: load=1, seed=0 → q=1000, zero_seed pulses for 1 cycle, count=0, period_len retains its prior value (15 after the first test).
- Reset mid-operation: rst=1 with en=1 and load=1, seed=0110, at q=1101 → next q=1000, count=0, period_len=0, no pulses.
- Non-maximal taps: WIDTH=4, TAPS=4'b0010, seed 1000, 20 steps → period_done never asserts; count reaches 20 mod 16 = 4.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, step enable and
// period tracking.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          advance one step this cycle
//   load        load seed this cycle (overrides en)
//   seed        value to load; all-zero is rejected and replaced by RESET_SEED
//   q           present LFSR state (registered)
//   out_bit     serial output, q[0]
//   count       steps since last reset, load or period completion
//   period_len  length of the last completed period
//   period_done one-cycle pulse when a step returns q to the start value
//   zero_seed   one-cycle pulse when an all-zero seed was rejected

module lfsr_gen #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b0011,
    parameter logic [WIDTH-1:0] RESET_SEED = 4'b1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             out_bit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] period_len,
    output logic             period_done,
    output logic             zero_seed
);

    // Reference value for period detection; only reset or load move it.
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] count_inc;
    logic             fb;
    logic             seed_zero;

    assign fb        = ^(q & TAPS);
    assign q_next    = {fb, q[WIDTH-1:1]};
    assign count_inc = count + WIDTH'(1);
    assign seed_zero = (seed == '0);
    assign out_bit   = q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= RESET_SEED;
            start       <= RESET_SEED;
            count       <= '0;
            period_len  <= '0;
            period_done <= 1'b0;
            zero_seed   <= 1'b0;
        end else if (load) begin
            // An all-zero seed would lock the register up, so fall back.
            q           <= seed_zero ? RESET_SEED : seed;
            start       <= seed_zero ? RESET_SEED : seed;
            zero_seed   <= seed_zero;
            count       <= '0;
            period_done <= 1'b0;
        end else if (en) begin
            q         <= q_next;
            zero_seed <= 1'b0;
            if (q_next == start) begin
                count       <= '0;
                period_len  <= count_inc;
                period_done <= 1'b1;
            end else begin
                count       <= count_inc;
                period_done <= 1'b0;
            end
        end else begin
            period_done <= 1'b0;
            zero_seed   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen with a maximal-tap instance and
// a non-invertible-tap instance driven by the same stimulus.

module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed = 4'd0;

    logic [3:0] q0, c0, p0;
    logic       ob0, pd0, zs0;
    logic [3:0] q1, c1, p1;
    logic       ob1, pd1, zs1;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .RESET_SEED(4'b1000)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
        .q(q0), .out_bit(ob0), .count(c0), .period_len(p0),
        .period_done(pd0), .zero_seed(zs0)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0010), .RESET_SEED(4'b1000)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
        .q(q1), .out_bit(ob1), .count(c1), .period_len(p1),
        .period_done(pd1), .zero_seed(zs1)
    );

    typedef struct {
        int q;
        int start;
        int cnt;
        int plen;
        bit pd;
        bit zs;
    } model_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    model_t m0, m1;
    model_t sb0[$];
    model_t sb1[$];

    // Next state as integer arithmetic: shift right, parity of tapped
    // bits enters at weight 8.
    function automatic int lfsr_next(int q, int taps);
        int par;
        par = $countones(q & taps) % 2;
        return (q / 2) + par * 8;
    endfunction

    function automatic model_t model_step(model_t m, bit r, bit e, bit l,
                                          int s, int taps);
        model_t n;
        n = m;
        n.pd = 0;
        n.zs = 0;
        if (r) begin
            n.q = 8; n.start = 8; n.cnt = 0; n.plen = 0;
        end else if (l) begin
            if (s == 0) begin
                n.q = 8; n.start = 8; n.zs = 1;
            end else begin
                n.q = s; n.start = s;
            end
            n.cnt = 0;
        end else if (e) begin
            n.q = lfsr_next(m.q, taps);
            if (n.q == m.start) begin
                n.plen = m.cnt + 1;
                n.cnt = 0;
                n.pd = 1;
            end else begin
                n.cnt = (m.cnt + 1) % 16;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req,
                     $time);
        end
    endtask

    // Driver: apply inputs at the falling edge and push the model's view
    // of the post-edge outputs into the scoreboards.
    task automatic drive(input bit r, input bit e, input bit l,
                         input int s);
        @(negedge clk);
        rst = r; en = e; load = l; seed = s[3:0];
        m0 = model_step(m0, r, e, l, s, 3);
        m1 = model_step(m1, r, e, l, s, 2);
        sb0.push_back(m0);
        sb1.push_back(m1);
    endtask

    // Monitor: every edge presents a fresh output set.
    always @(posedge clk) begin
        model_t e0, e1;
        #1;
        if (sb0.size() > 0) begin
            e0 = sb0.pop_front();
            chk("q0", int'(q0), e0.q);
            chk("out_bit0", int'(ob0), e0.q % 2);
            chk("count0", int'(c0), e0.cnt);
            chk("period_len0", int'(p0), e0.plen);
            chk("period_done0", int'(pd0), int'(e0.pd));
            chk("zero_seed0", int'(zs0), int'(e0.zs));
        end
        if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            chk("q1", int'(q1), e1.q);
            chk("out_bit1", int'(ob1), e1.q % 2);
            chk("count1", int'(c1), e1.cnt);
            chk("period_len1", int'(p1), e1.plen);
            chk("period_done1", int'(pd1), int'(e1.pd));
            chk("zero_seed1", int'(zs1), int'(e1.zs));
        end
    end

    // Directed check of the maximal sequence, sampled after the monitor.
    task automatic step_chk(input int req_q, input string name);
        drive(0, 1, 0, 0);
        @(posedge clk);
        #2;
        chk(name, int'(q0), req_q);
    endtask

    int seq[15] = '{4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3, 1, 8};
    int pd_seen;

    initial begin
        m0 = '{q: 8, start: 8, cnt: 0, plen: 0, pd: 0, zs: 0};
        m1 = m0;

        // Reset then one full period.
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        @(posedge clk); #2;
        chk("reset_q", int'(q0), 8);
        for (int i = 0; i < 15; i++) begin
            step_chk(seq[i], "seq_q");
            chk("seq_pd", int'(pd0), (i == 14) ? 1 : 0);
        end
        chk("full_period_len", int'(p0), 15);
        chk("full_period_cnt", int'(c0), 0);

        // Hold after three steps.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("hold_q", int'(q0), 9);
        chk("hold_cnt", int'(c0), 3);
        step_chk(12, "resume_q");

        // Load with en also high, then a full period from the new start.
        drive(0, 1, 1, 6);
        @(posedge clk); #2;
        chk("load_q", int'(q0), 6);
        chk("load_cnt", int'(c0), 0);
        pd_seen = 0;
        for (int i = 0; i < 15; i++) begin
            drive(0, 1, 0, 0);
            @(posedge clk); #2;
            if (pd0) pd_seen = i + 1;
        end
        chk("load_period_step", pd_seen, 15);
        chk("load_period_len", int'(p0), 15);

        // Rejected zero seed.
        drive(0, 0, 1, 0);
        @(posedge clk); #2;
        chk("zs_q", int'(q0), 8);
        chk("zs_pulse", int'(zs0), 1);
        chk("zs_plen", int'(p0), 15);
        drive(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("zs_clear", int'(zs0), 0);

        // Reset mid-operation at q=1101 with en and load also high.
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 0);
        @(posedge clk); #2;
        chk("pre_rst_q", int'(q0), 13);
        drive(1, 1, 1, 6);
        @(posedge clk); #2;
        chk("mid_rst_q", int'(q0), 8);
        chk("mid_rst_plen", int'(p0), 0);

        // Non-invertible taps: 20 steps, no period, count wraps.
        pd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0);
            @(posedge clk); #2;
            if (pd1) pd_seen++;
        end
        chk("nonmax_pd", pd_seen, 0);
        chk("nonmax_cnt", int'(c1), 4);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit r, e, l;
            int s;
            r = ($urandom_range(0, 99) < 3);
            l = ($urandom_range(0, 99) < 10);
            e = ($urandom_range(0, 99) < 75);
            s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            drive(r, e, l, s);
        end
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drained", sb0.size() + sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
